nn_layer_seq: RTL

Parametrised single-layer binary-input perceptron array with run-time loadable weights and thresholds. The layer evaluates N_OUT neurons over N_IN binary inputs and uses one shared input-serial MAC schedule: one input bit per cycle, all neurons in parallel. It replaces fixed-weight, combinational perceptron instances in the top-level wrapper: the config port connects to the bidirectional IO pins, and the layer output drives the dedicated outputs.

---
 rtl/nn_pkg.sv | 21 ++
 rtl/nn_layer_seq_if.sv | 29 ++
 rtl/nn_neuron_acc.sv | 45 ++++
 rtl/nn_layer_seq.sv | 121 ++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared constants for the binary-input perceptron layer:
// FSM encoding and config-image / accumulator sizing helpers.
package nn_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  function automatic int acc_width(input int w_w, input int n_in);
    return w_w + $clog2(n_in + 1);
  endfunction

  function automatic int n_cfg(input int n_out, input int n_in);
    return n_out * (n_in + 1);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nn_layer_seq_if.sv
// Config stream and evaluate request/response bundle
// of the perceptron layer.
interface nn_layer_seq_if #(
  parameter int N_IN  = 8,
  parameter int N_OUT = 8,
  parameter int W_W   = 8
) ();

  logic             cfg_valid;
  logic             cfg_ready;
  logic [W_W-1:0]   cfg_data;
  logic             cfg_loaded;
  logic             start;
  logic [N_IN-1:0]  x_in;
  logic             busy;
  logic             done;
  logic [N_OUT-1:0] y_out;

  modport master (
    output cfg_valid, cfg_data, start, x_in,
    input  cfg_ready, cfg_loaded, busy, done, y_out
  );

  modport slave (
    input  cfg_valid, cfg_data, start, x_in,
    output cfg_ready, cfg_loaded, busy, done, y_out
  );

endinterface

// File: rtl/nn_neuron_acc.sv
// One neuron: weight file, threshold and serial accumulator;
// activation is a strict compare of acc against threshold.
module nn_neuron_acc
  import nn_pkg::*;
#(
  parameter int N_IN = 8,
  parameter int W_W  = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_wen,
  input  logic [idx_width(N_IN)-1:0]     i_widx,
  input  logic                           i_ten,
  input  logic [W_W-1:0]                 i_data,
  input  logic                           i_clear,
  input  logic                           i_step,
  input  logic                           i_x_bit,
  input  logic [idx_width(N_IN)-1:0]     i_idx,
  output logic                           o_act
);

  localparam int ACC_W = acc_width(W_W, N_IN);

  logic [W_W-1:0]   r_w [N_IN];
  logic [W_W-1:0]   r_thr;
  logic [ACC_W-1:0] r_acc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < N_IN; k++) r_w[k] <= '0;
      r_thr <= '0;
      r_acc <= '0;
    end else begin
      if (i_wen) r_w[i_widx] <= i_data;
      if (i_ten) r_thr <= i_data;
      if (i_clear)
        r_acc <= '0;
      else if (i_step && i_x_bit)
        r_acc <= r_acc + ACC_W'(r_w[i_idx]);
    end
  end

  assign o_act = r_acc > ACC_W'(r_thr);

endmodule

// File: rtl/nn_layer_seq.sv
// Perceptron layer: input-serial MAC over N_IN cycles, all
// neurons in parallel, with a streamed weight/threshold image.
module nn_layer_seq
  import nn_pkg::*;
#(
  parameter int N_IN  = 8,
  parameter int N_OUT = 8,
  parameter int W_W   = 8
) (
  input logic           clk,
  input logic           rst_n,
  nn_layer_seq_if.slave bus
);

  localparam int NCFG = n_cfg(N_OUT, N_IN);
  localparam int NWT  = N_OUT * N_IN;
  localparam int PW   = idx_width(NCFG);
  localparam int IW   = idx_width(N_IN);
  localparam int NW   = idx_width(N_OUT);

  logic [1:0]       r_state;
  logic [PW-1:0]    r_ptr;
  logic             r_loaded;
  logic [IW-1:0]    r_i;
  logic [N_IN-1:0]  r_x;
  logic [N_OUT-1:0] r_y;
  logic             r_done;

  logic             w_start_acc;
  logic             w_cfg_acc;
  logic             w_is_thr;
  logic [NW-1:0]    w_sel;
  logic [IW-1:0]    w_widx;
  logic [N_OUT-1:0] w_act;

  assign bus.cfg_ready  = (r_state == S_IDLE) && !bus.start;
  assign bus.cfg_loaded = r_loaded;
  assign bus.busy       = (r_state == S_RUN);
  assign bus.done       = r_done;
  assign bus.y_out      = r_y;

  assign w_start_acc = bus.start && (r_state == S_IDLE);
  assign w_cfg_acc   = bus.cfg_valid && bus.cfg_ready;

  // Map the flat config pointer onto neuron/weight or threshold slot.
  always_comb begin
    int p;
    p        = int'(r_ptr);
    w_is_thr = (p >= NWT);
    w_sel    = '0;
    w_widx   = '0;
    if (w_is_thr) begin
      w_sel = NW'(p - NWT);
    end else begin
      w_sel  = NW'(p / N_IN);
      w_widx = IW'(p % N_IN);
    end
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_neu
    nn_neuron_acc #(.N_IN(N_IN), .W_W(W_W)) u_acc (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_wen   (w_cfg_acc && !w_is_thr && (w_sel == NW'(g))),
      .i_widx  (w_widx),
      .i_ten   (w_cfg_acc && w_is_thr && (w_sel == NW'(g))),
      .i_data  (bus.cfg_data),
      .i_clear (w_start_acc),
      .i_step  (r_state == S_RUN),
      .i_x_bit (r_x[r_i]),
      .i_idx   (r_i),
      .o_act   (w_act[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr    <= '0;
      r_loaded <= 1'b0;
    end else if (w_cfg_acc) begin
      if (r_ptr == PW'(NCFG - 1)) begin
        r_ptr    <= '0;
        r_loaded <= 1'b1;
      end else begin
        r_ptr <= r_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_i     <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_x     <= bus.x_in;
            r_i     <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_i <= r_i + 1'b1;
          if (r_i == IW'(N_IN - 1)) r_state <= S_DONE;
        end
        S_DONE: begin
          r_y     <= w_act;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
